dm_stage_ctrl: RTL and testbench

Data-memory stage controller sitting directly downstream of the EX/DM pipeline register and upstream of the register-file write-back.
- Consumes the EX/DM outputs: address, store data, mem_read/mem_write, mem_to_reg, reg_write and rd.
- Runs a req/ack handshake with a variable-latency data memory and stalls the upstream pipeline while an access is outstanding.
- Presents registered DM/WB outputs to the write-back stage.

---
 rtl/dm_stage_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dm_stage_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_stage_ctrl.sv
// Data-memory stage controller: drives a req/ack data memory, stalls upstream while
// an access is outstanding, registers DM/WB outputs. Optional macro: MISALIGN_CHECK_EN.
module dm_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] mem_address,
    input  logic [31:0] write_data_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic        mem_error
);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [31:0]       dmem_addr_q, dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic              hold_reg_write_q, hold_reg_write_d;
    logic              hold_mem_to_reg_q, hold_mem_to_reg_d;
    logic              hold_is_load_q, hold_is_load_d;
    logic [4:0]        hold_rd_q, hold_rd_d;
    logic [31:0]       hold_alu_q, hold_alu_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_read_data_q, wb_read_data_d;
    logic [31:0]       wb_alu_result_q, wb_alu_result_d;
    logic              mem_error_q, mem_error_d;

    logic memop;
    logic rd_nonzero;
    logic misaligned;

    assign memop      = in_valid & (mem_read_in | mem_write_in);
    assign rd_nonzero = (rd_in != 5'd0);

`ifdef MISALIGN_CHECK_EN
    assign misaligned = (mem_address[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Gated by reset so the upstream sees no stall while reset is held.
    assign stall_out = ~reset & ((state_q == ACCESS) | ((state_q == IDLE) & memop));

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        dmem_req_d        = dmem_req_q;
        dmem_we_d         = dmem_we_q;
        dmem_addr_d       = dmem_addr_q;
        dmem_wdata_d      = dmem_wdata_q;
        hold_reg_write_d  = hold_reg_write_q;
        hold_mem_to_reg_d = hold_mem_to_reg_q;
        hold_is_load_d    = hold_is_load_q;
        hold_rd_d         = hold_rd_q;
        hold_alu_d        = hold_alu_q;
        wb_valid_d        = wb_valid_q;
        wb_reg_write_d    = wb_reg_write_q;
        wb_mem_to_reg_d   = wb_mem_to_reg_q;
        wb_rd_d           = wb_rd_q;
        wb_read_data_d    = wb_read_data_q;
        wb_alu_result_d   = wb_alu_result_q;
        mem_error_d       = mem_error_q;

        case (state_q)
            IDLE: begin
                if (memop && misaligned) begin
                    mem_error_d     = 1'b1;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = 1'b0;
                    wb_mem_to_reg_d = mem_to_reg_in;
                    wb_rd_d         = rd_in;
                    wb_read_data_d  = 32'd0;
                    wb_alu_result_d = mem_address;
                end else if (memop) begin
                    // A set write bit wins over read: the access is a store.
                    state_d           = ACCESS;
                    cnt_d             = '0;
                    dmem_req_d        = 1'b1;
                    dmem_we_d         = mem_write_in;
                    dmem_addr_d       = {mem_address[31:2], 2'b00};
                    dmem_wdata_d      = write_data_in;
                    hold_reg_write_d  = reg_write_in & ~mem_write_in & rd_nonzero;
                    hold_mem_to_reg_d = mem_to_reg_in;
                    hold_is_load_d    = ~mem_write_in;
                    hold_rd_d         = rd_in;
                    hold_alu_d        = mem_address;
                    wb_valid_d        = 1'b0;
                    wb_reg_write_d    = 1'b0;
                end else begin
                    wb_valid_d      = in_valid;
                    wb_reg_write_d  = reg_write_in & in_valid & rd_nonzero;
                    wb_mem_to_reg_d = mem_to_reg_in;
                    wb_rd_d         = rd_in;
                    wb_read_data_d  = 32'd0;
                    wb_alu_result_d = mem_address;
                end
            end
            ACCESS: begin
                wb_valid_d     = 1'b0;
                wb_reg_write_d = 1'b0;
                if (dmem_ack) begin
                    state_d         = IDLE;
                    dmem_req_d      = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = hold_reg_write_q;
                    wb_mem_to_reg_d = hold_mem_to_reg_q;
                    wb_rd_d         = hold_rd_q;
                    wb_read_data_d  = hold_is_load_q ? dmem_rdata : 32'd0;
                    wb_alu_result_d = hold_alu_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    dmem_req_d      = 1'b0;
                    mem_error_d     = 1'b1;
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = 1'b0;
                    wb_mem_to_reg_d = hold_mem_to_reg_q;
                    wb_rd_d         = hold_rd_q;
                    wb_read_data_d  = 32'd0;
                    wb_alu_result_d = hold_alu_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            dmem_req_q        <= 1'b0;
            dmem_we_q         <= 1'b0;
            dmem_addr_q       <= 32'd0;
            dmem_wdata_q      <= 32'd0;
            hold_reg_write_q  <= 1'b0;
            hold_mem_to_reg_q <= 1'b0;
            hold_is_load_q    <= 1'b0;
            hold_rd_q         <= 5'd0;
            hold_alu_q        <= 32'd0;
            wb_valid_q        <= 1'b0;
            wb_reg_write_q    <= 1'b0;
            wb_mem_to_reg_q   <= 1'b0;
            wb_rd_q           <= 5'd0;
            wb_read_data_q    <= 32'd0;
            wb_alu_result_q   <= 32'd0;
            mem_error_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            dmem_req_q        <= dmem_req_d;
            dmem_we_q         <= dmem_we_d;
            dmem_addr_q       <= dmem_addr_d;
            dmem_wdata_q      <= dmem_wdata_d;
            hold_reg_write_q  <= hold_reg_write_d;
            hold_mem_to_reg_q <= hold_mem_to_reg_d;
            hold_is_load_q    <= hold_is_load_d;
            hold_rd_q         <= hold_rd_d;
            hold_alu_q        <= hold_alu_d;
            wb_valid_q        <= wb_valid_d;
            wb_reg_write_q    <= wb_reg_write_d;
            wb_mem_to_reg_q   <= wb_mem_to_reg_d;
            wb_rd_q           <= wb_rd_d;
            wb_read_data_q    <= wb_read_data_d;
            wb_alu_result_q   <= wb_alu_result_d;
            mem_error_q       <= mem_error_d;
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_rd         = wb_rd_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign mem_error     = mem_error_q;

endmodule

// File: tb/tb_dm_stage_ctrl.sv
// Self-checking bench for dm_stage_ctrl: directed scenarios plus randomized operations
// checked against a transaction-level model of the data-memory stage.
module tb_dm_stage_ctrl;

    localparam int TIMEOUT = 16;
`ifdef MISALIGN_CHECK_EN
    localparam bit MISALIGN = 1'b1;
`else
    localparam bit MISALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [4:0]  rd_in;
    logic [31:0] mem_address, write_data_in;
    logic        stall_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_read_data, wb_alu_result;
    logic        mem_error;

    int checks = 0;
    int errors = 0;
    int cycles = 0;
    logic exp_err = 1'b0;

    typedef struct {
        logic        v, r, w, m2r, rw;
        logic [4:0]  rd;
        logic [31:0] addr, wdata;
        int          ack_at;
        logic [31:0] rdata;
    } op_t;

    typedef struct {
        logic        valid, reg_write, mem_to_reg, err, issued, we0, stable, hung;
        logic [4:0]  rd;
        logic [31:0] read_data, alu, addr0, wdata0;
        int          stall_cycles, access_cycles;
    } obs_t;

    dm_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .mem_address(mem_address),
        .write_data_in(write_data_in), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .mem_error(mem_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    // Expected outcome of one operation, from the stage's rules rather than its states.
    function automatic obs_t model_op(input op_t op, input logic err_prev);
        obs_t e;
        logic memop;
        e = '{default: '0};
        memop = op.v & (op.r | op.w);
        e.err = err_prev;
        e.mem_to_reg = op.m2r;
        e.rd = op.rd;
        e.alu = op.addr;
        if (!memop) begin
            e.valid = op.v;
            e.reg_write = op.rw & op.v & (op.rd != 5'd0);
        end else if (MISALIGN && op.addr[1:0] != 2'b00) begin
            e.stall_cycles = 1;
            e.valid = 1'b1;
            e.err = 1'b1;
        end else begin
            e.issued = 1'b1;
            e.we0 = op.w;
            e.addr0 = {op.addr[31:2], 2'b00};
            e.wdata0 = op.wdata;
            e.stable = 1'b1;
            e.valid = 1'b1;
            if (op.ack_at >= 1 && op.ack_at <= TIMEOUT) begin
                e.access_cycles = op.ack_at;
                e.reg_write = op.rw & ~op.w & (op.rd != 5'd0);
                e.read_data = op.w ? 32'd0 : op.rdata;
            end else begin
                e.access_cycles = TIMEOUT;
                e.err = 1'b1;
            end
            e.stall_cycles = e.access_cycles + 1;
        end
        return e;
    endfunction

    // Drives one operation starting at posedge+1 and acts as the memory; no checking here.
    task automatic run_op(input op_t op, output obs_t o);
        int acc;
        o = '{default: '0};
        in_valid = op.v; mem_read_in = op.r; mem_write_in = op.w;
        mem_to_reg_in = op.m2r; reg_write_in = op.rw; rd_in = op.rd;
        mem_address = op.addr; write_data_in = op.wdata; dmem_ack = 1'b0;
        #1;
        if (stall_out) o.stall_cycles = 1;
        @(posedge clk); #1;
        if (dmem_req) begin
            o.issued = 1'b1; o.we0 = dmem_we; o.addr0 = dmem_addr;
            o.wdata0 = dmem_wdata; o.stable = 1'b1;
            acc = 0;
            while (dmem_req && acc < 64) begin
                acc++;
                dmem_ack = (acc == op.ack_at);
                dmem_rdata = dmem_ack ? op.rdata : $urandom();
                #1;
                if (stall_out) o.stall_cycles++;
                if (dmem_we !== o.we0 || dmem_addr !== o.addr0 || dmem_wdata !== o.wdata0 ||
                    wb_valid !== 1'b0)
                    o.stable = 1'b0;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
            end
            o.access_cycles = acc;
            o.hung = dmem_req;
        end
        o.valid = wb_valid; o.reg_write = wb_reg_write; o.mem_to_reg = wb_mem_to_reg;
        o.rd = wb_rd; o.read_data = wb_read_data; o.alu = wb_alu_result; o.err = mem_error;
    endtask

    task automatic go_idle();
        in_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        mem_to_reg_in = 1'b0; reg_write_in = 1'b0; rd_in = 5'd0;
        mem_address = 32'd0; write_data_in = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go_idle();
        in_valid = 1'b1; mem_read_in = 1'b1;
        #3;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_out);
        end
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_mem_to_reg,
             wb_rd, wb_read_data, wb_alu_result, mem_error} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs: some output nonzero, expected all 0");
        end
        go_idle();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_op();
        op_t op; obs_t o, e;
        op = '{v:1, r:0, w:0, m2r:0, rw:1, rd:5'd5, addr:32'h1234, wdata:32'h0, ack_at:0, rdata:32'h0};
        e = model_op(op, exp_err);
        run_op(op, o);
        exp_err = e.err;
        checks++;
        if (o.valid !== 1'b1 || o.reg_write !== 1'b1 || o.rd !== 5'd5 || o.alu !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL alu_wb: got v=%b rw=%b rd=%0d alu=%h expected 1 1 5 1234",
                     o.valid, o.reg_write, o.rd, o.alu);
        end
        checks++;
        if (o.stall_cycles != 0 || o.issued !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alu_stall: got stall=%0d issued=%b expected 0 0", o.stall_cycles, o.issued);
        end
        go_idle();
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0 || wb_read_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL idle_ack: got req=%b stall=%b v=%b rdata=%h expected 0 0 0 0",
                     dmem_req, stall_out, wb_valid, wb_read_data);
        end
    endtask

    task automatic test_load();
        op_t op; obs_t o, e;
        op = '{v:1, r:1, w:0, m2r:1, rw:1, rd:5'd7, addr:32'h40, wdata:32'h0, ack_at:3, rdata:32'hDEADBEEF};
        e = model_op(op, exp_err);
        run_op(op, o);
        exp_err = e.err;
        checks++;
        if (o.stall_cycles != 4) begin
            errors++; $display("[TB] FAIL load_stall: got %0d expected 4", o.stall_cycles);
        end
        checks++;
        if (o.read_data !== 32'hDEADBEEF || o.mem_to_reg !== 1'b1 || o.valid !== 1'b1 || o.reg_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_wb: got data=%h m2r=%b v=%b rw=%b expected deadbeef 1 1 1",
                     o.read_data, o.mem_to_reg, o.valid, o.reg_write);
        end
        checks++;
        if (o.addr0 !== e.addr0 || o.we0 !== 1'b0 || o.stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_req: got addr=%h we=%b stable=%b expected %h 0 1", o.addr0, o.we0, o.stable, e.addr0);
        end
        go_idle();
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("[TB] FAIL load_stall_fall: got %b expected 0", stall_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        op_t op; obs_t o;
        op = '{v:1, r:0, w:1, m2r:0, rw:1, rd:5'd9, addr:32'h80, wdata:32'h55, ack_at:2, rdata:32'h1111};
        run_op(op, o);
        checks++;
        if (o.we0 !== 1'b1 || o.wdata0 !== 32'h55 || o.addr0 !== 32'h80 || o.stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_req: got we=%b wdata=%h addr=%h stable=%b expected 1 55 80 1",
                     o.we0, o.wdata0, o.addr0, o.stable);
        end
        checks++;
        if (o.reg_write !== 1'b0 || o.valid !== 1'b1 || o.read_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL store_wb: got rw=%b v=%b data=%h expected 0 1 0", o.reg_write, o.valid, o.read_data);
        end
    endtask

    task automatic test_timeout();
        op_t op; obs_t o;
        op = '{v:1, r:1, w:0, m2r:1, rw:1, rd:5'd4, addr:32'h100, wdata:32'h0, ack_at:0, rdata:32'h0};
        run_op(op, o);
        exp_err = 1'b1;
        checks++;
        if (o.access_cycles != TIMEOUT || o.hung !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d hung=%b expected %0d 0", o.access_cycles, o.hung, TIMEOUT);
        end
        checks++;
        if (o.err !== 1'b1 || o.reg_write !== 1'b0 || o.valid !== 1'b1 || o.read_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL timeout_wb: got err=%b rw=%b v=%b data=%h expected 1 0 1 0",
                     o.err, o.reg_write, o.valid, o.read_data);
        end
        op = '{v:1, r:0, w:0, m2r:0, rw:1, rd:5'd12, addr:32'hABC, wdata:32'h0, ack_at:0, rdata:32'h0};
        run_op(op, o);
        checks++;
        if (o.valid !== 1'b1 || o.reg_write !== 1'b1 || o.rd !== 5'd12 || o.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_next: got v=%b rw=%b rd=%0d err=%b expected 1 1 12 1",
                     o.valid, o.reg_write, o.rd, o.err);
        end
    endtask

    task automatic test_reset_access();
        op_t op; obs_t o;
        in_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1;
        rd_in = 5'd3; mem_address = 32'h200; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_acc_pre: got req=%b expected 1", dmem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dmem_req, stall_out, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, wb_read_data,
             wb_alu_result, mem_error} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_acc: got req=%b stall=%b v=%b rd=%0d alu=%h err=%b expected all 0",
                     dmem_req, stall_out, wb_valid, wb_rd, wb_alu_result, mem_error);
        end
        exp_err = 1'b0;
        go_idle();
        #1 reset = 1'b0;
        @(posedge clk); #1;
        op = '{v:1, r:0, w:0, m2r:1, rw:1, rd:5'd6, addr:32'h77, wdata:32'h0, ack_at:0, rdata:32'h0};
        run_op(op, o);
        checks++;
        if (o.valid !== 1'b1 || o.reg_write !== 1'b1 || o.stall_cycles != 0 || o.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_acc_after: got v=%b rw=%b stall=%0d err=%b expected 1 1 0 0",
                     o.valid, o.reg_write, o.stall_cycles, o.err);
        end
    endtask

    task automatic test_rd_zero();
        op_t op; obs_t o, e;
        op = '{v:1, r:1, w:0, m2r:1, rw:1, rd:5'd0, addr:32'h42, wdata:32'h0, ack_at:2, rdata:32'hCAFE};
        e = model_op(op, exp_err);
        run_op(op, o);
        exp_err = e.err;
        checks++;
        if (o.reg_write !== 1'b0 || o.issued !== e.issued || o.err !== e.err) begin
            errors++;
            $display("[TB] FAIL rd_zero: got rw=%b issued=%b err=%b expected 0 %b %b",
                     o.reg_write, o.issued, o.err, e.issued, e.err);
        end
        if (e.issued) begin
            checks++;
            if (o.addr0 !== 32'h40) begin
                errors++; $display("[TB] FAIL rd_zero_addr: got %h expected 40", o.addr0);
            end
        end
    endtask

    task automatic test_both_rw();
        op_t op; obs_t o;
        op = '{v:1, r:1, w:1, m2r:1, rw:1, rd:5'd3, addr:32'h300, wdata:32'h9999, ack_at:1, rdata:$urandom()};
        run_op(op, o);
        checks++;
        if (o.we0 !== 1'b1 || o.reg_write !== 1'b0 || o.read_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL both_rw: got we=%b rw=%b data=%h expected 1 0 0", o.we0, o.reg_write, o.read_data);
        end
    endtask

    task automatic test_back_to_back();
        op_t a, b; obs_t oa, ob;
        int start;
        a = '{v:1, r:1, w:0, m2r:1, rw:1, rd:5'd10, addr:32'h500, wdata:32'h0, ack_at:1, rdata:32'h1234_5678};
        b = '{v:1, r:1, w:0, m2r:1, rw:1, rd:5'd11, addr:32'h504, wdata:32'h0, ack_at:2, rdata:32'h8765_4321};
        start = cycles;
        run_op(a, oa);
        run_op(b, ob);
        checks++;
        if (cycles - start != 5) begin
            errors++; $display("[TB] FAIL b2b_cycles: got %0d expected 5", cycles - start);
        end
        checks++;
        if (oa.read_data !== 32'h1234_5678 || ob.read_data !== 32'h8765_4321 || ob.rd !== 5'd11) begin
            errors++;
            $display("[TB] FAIL b2b_data: got %h %h rd=%0d expected 12345678 87654321 11",
                     oa.read_data, ob.read_data, ob.rd);
        end
    endtask

    task automatic test_random();
        op_t op; obs_t o, e;
        for (int n = 0; n < 40; n++) begin
            op.v = ($urandom_range(0, 7) != 0);
            op.r = $urandom_range(0, 1);
            op.w = ($urandom_range(0, 2) == 0);
            op.m2r = $urandom_range(0, 1);
            op.rw = $urandom_range(0, 1);
            op.rd = 5'($urandom_range(0, 31));
            op.addr = $urandom();
            if ($urandom_range(0, 3) != 0) op.addr[1:0] = 2'b00;
            op.wdata = $urandom();
            op.ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            op.rdata = $urandom();
            e = model_op(op, exp_err);
            run_op(op, o);
            exp_err = e.err;
            checks++;
            if (o.valid !== e.valid || o.reg_write !== e.reg_write || o.mem_to_reg !== e.mem_to_reg ||
                o.rd !== e.rd || o.alu !== e.alu || o.read_data !== e.read_data || o.err !== e.err) begin
                errors++;
                $display("[TB] FAIL rand_wb[%0d]: got v=%b rw=%b m2r=%b rd=%0d alu=%h data=%h err=%b expected %b %b %b %0d %h %h %b",
                         n, o.valid, o.reg_write, o.mem_to_reg, o.rd, o.alu, o.read_data, o.err,
                         e.valid, e.reg_write, e.mem_to_reg, e.rd, e.alu, e.read_data, e.err);
            end
            checks++;
            if (o.stall_cycles != e.stall_cycles || o.issued !== e.issued) begin
                errors++;
                $display("[TB] FAIL rand_stall[%0d]: got stall=%0d issued=%b expected %0d %b",
                         n, o.stall_cycles, o.issued, e.stall_cycles, e.issued);
            end
            if (e.issued) begin
                checks++;
                if (o.we0 !== e.we0 || o.addr0 !== e.addr0 || o.wdata0 !== e.wdata0 || o.stable !== 1'b1 ||
                    o.access_cycles != e.access_cycles || o.hung !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand_req[%0d]: got we=%b addr=%h wd=%h st=%b acc=%0d expected %b %h %h 1 %0d",
                             n, o.we0, o.addr0, o.wdata0, o.stable, o.access_cycles,
                             e.we0, e.addr0, e.wdata0, e.access_cycles);
                end
            end
        end
        go_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_timeout();
        test_reset_access();
        test_rd_zero();
        test_both_rw();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
